// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared width constant and opcode encoding for alu_32bit
package alu_pkg;
   localparam int WIDTH = 32;

   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_AND = 3'b010,
      ALU_OR  = 3'b011,
      ALU_XOR = 3'b100,
      ALU_SLL = 3'b101,
      ALU_SRL = 3'b110,
      ALU_SLT = 3'b111
   } alu_op_t;
endpackage

// File: rtl/alu_shifter.sv
// rtl/alu_shifter.sv - logarithmic barrel shifter, logical left/right with zero fill
module alu_shifter #(
   parameter int WIDTH = 32,
   parameter int SHAMT_W = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0]   data,
   input  logic [SHAMT_W-1:0] amount,
   input  logic               right,
   output logic [WIDTH-1:0]   shifted
);

   logic [WIDTH-1:0] stage;

   // one stage per amount bit, each shifting by a power of two
   always_comb begin
      stage = data;
      for (int i = 0; i < SHAMT_W; i++) begin
         if (amount[i]) begin
            stage = right ? (stage >> (1 << i)) : (stage << (1 << i));
         end
      end
      shifted = stage;
   end
endmodule

// File: rtl/alu_32bit.sv
// rtl/alu_32bit.sv - 8-op integer ALU, combinational result plus registered copy
// Status flags are built and registered only when ALU_FLAGS_EN is defined; otherwise tied to 0.
module alu_32bit
   import alu_pkg::*;
#(
   parameter int WIDTH = alu_pkg::WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] operandA,
   input  logic [WIDTH-1:0] operandB,
   input  logic [2:0]       ALUControl,
   input  logic             en,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] result_q,
   output logic             zero_q,
   output logic             neg_q,
   output logic             carry_q,
   output logic             ovf_q
);

   localparam int SHAMT_W = $clog2(WIDTH);

   alu_op_t          op;
   logic             is_sub;
   logic [WIDTH-1:0] b_eff;
   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] shifted;
   logic             slt;

   assign op     = alu_op_t'(ALUControl);
   assign is_sub = (op == ALU_SUB);
   assign b_eff  = is_sub ? ~operandB : operandB;

`ifdef ALU_FLAGS_EN
   logic carry;
   logic ovf;
   logic is_arith;

   // subtraction is A + ~B + 1, so carry-out doubles as "no borrow"
   assign {carry, sum} = {1'b0, operandA} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
   assign ovf = (operandA[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != operandA[WIDTH-1]);
   assign is_arith = (op == ALU_ADD) || (op == ALU_SUB);
`else
   assign sum = operandA + b_eff + {{(WIDTH-1){1'b0}}, is_sub};
`endif

   assign slt = $signed(operandA) < $signed(operandB);

   alu_shifter #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) u_shifter (
      .data    (operandA),
      .amount  (operandB[SHAMT_W-1:0]),
      .right   (op == ALU_SRL),
      .shifted (shifted)
   );

   always_comb begin
      result = '0;
      unique case (op)
         ALU_ADD, ALU_SUB: result = sum;
         ALU_AND:          result = operandA & operandB;
         ALU_OR:           result = operandA | operandB;
         ALU_XOR:          result = operandA ^ operandB;
         ALU_SLL, ALU_SRL: result = shifted;
         ALU_SLT:          result = {{(WIDTH-1){1'b0}}, slt};
         default:          result = '0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         result_q <= '0;
      end else if (en) begin
         result_q <= result;
      end
   end

`ifdef ALU_FLAGS_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         zero_q  <= 1'b0;
         neg_q   <= 1'b0;
         carry_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else if (en) begin
         zero_q  <= (result == '0);
         neg_q   <= result[WIDTH-1];
         carry_q <= is_arith & carry;
         ovf_q   <= is_arith & ovf;
      end
   end
`else
   assign zero_q  = 1'b0;
   assign neg_q   = 1'b0;
   assign carry_q = 1'b0;
   assign ovf_q   = 1'b0;
`endif
endmodule

// File: tb/tb_alu_32bit.sv
// tb/tb_alu_32bit.sv - self-checking bench for alu_32bit (directed table, corner sequences, random)
// Flag expectations follow ALU_FLAGS_EN: modelled when defined, expected 0 otherwise.
module tb_alu_32bit;

`ifdef ALU_FLAGS_EN
   localparam bit FLAGS = 1'b1;
`else
   localparam bit FLAGS = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] operandA;
   logic [31:0] operandB;
   logic [2:0]  ALUControl;
   logic        en;
   logic [31:0] result;
   logic [31:0] result_q;
   logic        zero_q;
   logic        neg_q;
   logic        carry_q;
   logic        ovf_q;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [31:0] res;
      logic        zero;
      logic        neg;
      logic        carry;
      logic        ovf;
   } model_t;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
   } vec_t;

   alu_32bit dut (
      .clk        (clk),
      .reset      (reset),
      .operandA   (operandA),
      .operandB   (operandB),
      .ALUControl (ALUControl),
      .en         (en),
      .result     (result),
      .result_q   (result_q),
      .zero_q     (zero_q),
      .neg_q      (neg_q),
      .carry_q    (carry_q),
      .ovf_q      (ovf_q)
   );

   always #5 clk = ~clk;

   // reference: arithmetic done in 64 bits, flags judged from the exact result
   function automatic model_t ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      model_t m;
      longint sa, sb, wide;
      longint unsigned ua, ub;
      int r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      wide = 0;
      m.carry = 1'b0;
      m.ovf = 1'b0;
      case (op)
         3'd0: begin m.res = 32'(ua + ub); m.carry = (ua + ub) > 64'hFFFF_FFFF; wide = sa + sb; end
         3'd1: begin m.res = 32'(ua - ub); m.carry = (ua >= ub); wide = sa - sb; end
         3'd2: m.res = a & b;
         3'd3: m.res = a | b;
         3'd4: m.res = a ^ b;
         3'd5: m.res = a << b[4:0];
         3'd6: m.res = a >> b[4:0];
         default: m.res = (sa < sb) ? 32'd1 : 32'd0;
      endcase
      r = m.res;
      if (op == 3'd0 || op == 3'd1) m.ovf = (wide != longint'(r));
      m.zero = (m.res == 32'd0);
      m.neg = m.res[31];
      if (!FLAGS) begin
         m.zero = 1'b0; m.neg = 1'b0; m.carry = 1'b0; m.ovf = 1'b0;
      end
      return m;
   endfunction

   function automatic vec_t mkv(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [31:0] res);
      vec_t v;
      v.op = op; v.a = a; v.b = b; v.res = res;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_regs(input string tag, input model_t e);
      check({tag, ".result_q"}, result_q, e.res);
      check({tag, ".zero_q"}, {31'd0, zero_q}, {31'd0, e.zero});
      check({tag, ".neg_q"}, {31'd0, neg_q}, {31'd0, e.neg});
      check({tag, ".carry_q"}, {31'd0, carry_q}, {31'd0, e.carry});
      check({tag, ".ovf_q"}, {31'd0, ovf_q}, {31'd0, e.ovf});
   endtask

   task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic e);
      ALUControl = op; operandA = a; operandB = b; en = e;
   endtask

   vec_t   vecs[17];
   model_t zero_m;
   model_t held;
   model_t m;

   initial begin
      zero_m = '{res: 32'd0, zero: 1'b0, neg: 1'b0, carry: 1'b0, ovf: 1'b0};

      vecs[0]  = mkv(3'd0, 32'h3210_0000, 32'h0001_0000, 32'h3211_0000);
      vecs[1]  = mkv(3'd1, 32'h3210_0000, 32'h0001_0000, 32'h320F_0000);
      vecs[2]  = mkv(3'd2, 32'hFFFF_FFFF, 32'h0000_FFFF, 32'h0000_FFFF);
      vecs[3]  = mkv(3'd3, 32'hFFFF_FFFF, 32'h0000_FFFF, 32'hFFFF_FFFF);
      vecs[4]  = mkv(3'd4, 32'hFFFF_FFFF, 32'h0000_FFFF, 32'hFFFF_0000);
      vecs[5]  = mkv(3'd5, 32'h1234_5678, 32'h0000_0002, 32'h48D1_59E0);
      vecs[6]  = mkv(3'd6, 32'h1234_5678, 32'h0000_0002, 32'h048D_159E);
      vecs[7]  = mkv(3'd5, 32'h1234_5678, 32'hFFFF_FFE2, 32'h48D1_59E0);
      vecs[8]  = mkv(3'd6, 32'h1234_5678, 32'hFFFF_FFE2, 32'h048D_159E);
      vecs[9]  = mkv(3'd7, 32'h1234_5678, 32'h9876_5432, 32'h0000_0000);
      vecs[10] = mkv(3'd7, 32'h9876_5432, 32'h1234_5678, 32'h0000_0001);
      vecs[11] = mkv(3'd0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000);
      vecs[12] = mkv(3'd7, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001);
      vecs[13] = mkv(3'd7, 32'hABCD_0123, 32'hABCD_0123, 32'h0000_0000);
      vecs[14] = mkv(3'd5, 32'hDEAD_BEEF, 32'hFFFF_FFE0, 32'hDEAD_BEEF);
      vecs[15] = mkv(3'd6, 32'h8000_0000, 32'h0000_001F, 32'h0000_0001);
      vecs[16] = mkv(3'd1, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF);

      reset = 1'b1;
      drive(3'd0, 32'd0, 32'd0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      check_regs("reset", zero_m);
      reset = 1'b0;

      foreach (vecs[i]) begin
         drive(vecs[i].op, vecs[i].a, vecs[i].b, 1'b1);
         #1;
         check($sformatf("vec%0d.result", i), result, vecs[i].res);
         @(posedge clk);
         #1;
         m = ref_model(vecs[i].op, vecs[i].a, vecs[i].b);
         check($sformatf("vec%0d.result_q", i), result_q, vecs[i].res);
         check_regs($sformatf("vec%0d", i), m);
      end

      // hold with en low while inputs keep changing
      drive(3'd1, 32'h3210_0000, 32'h0001_0000, 1'b1);
      @(posedge clk);
      #1;
      held = ref_model(3'd1, 32'h3210_0000, 32'h0001_0000);
      for (int k = 0; k < 3; k++) begin
         drive(3'd4, $urandom, $urandom, 1'b0);
         @(posedge clk);
         #1;
         check_regs($sformatf("hold%0d", k), held);
      end

      // SUB of equal operands
      drive(3'd1, 32'd5, 32'd5, 1'b1);
      @(posedge clk);
      #1;
      check_regs("sub_eq", ref_model(3'd1, 32'd5, 32'd5));
      check("sub_eq.zero_q", {31'd0, zero_q}, {31'd0, FLAGS});

      // reset mid-cycle clears registers before the next edge, result stays live
      drive(3'd0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1);
      @(posedge clk);
      #1;
      check("prereset.result_q", result_q, 32'h8000_0000);
      #2;
      reset = 1'b1;
      #1;
      check_regs("midreset", zero_m);
      check("midreset.result", result, 32'h8000_0000);
      @(posedge clk);
      #1;
      check_regs("inreset", zero_m);
      reset = 1'b0;

      // randomized run against the reference model
      held = zero_m;
      for (int k = 0; k < 200; k++) begin
         logic [2:0]  op;
         logic [31:0] a, b;
         logic        e;
         op = 3'($urandom_range(0, 7));
         a  = $urandom;
         b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
         if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
         e  = 1'($urandom_range(0, 3) != 0);
         drive(op, a, b, e);
         #1;
         m = ref_model(op, a, b);
         check($sformatf("rnd%0d.result", k), result, m.res);
         @(posedge clk);
         #1;
         if (e) held = m;
         check_regs($sformatf("rnd%0d", k), held);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
